// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker fetch/decode/execute/writeback sequencer.
package tinker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;

    localparam logic [4:0]  DEFAULT_HALT_OPCODE = 5'h0F;
    localparam logic [63:0] PC_INCR             = 64'd4;

    function automatic logic [4:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/tinker_exec_watchdog.sv
// EXECUTE-phase watchdog: counts stalled cycles and flags the last allowed one.
module tinker_exec_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic first,
    output logic tc
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // count holds the number of EXECUTE cycles already spent, so tc marks the final one
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign first = (count == '0);
    assign tc    = (count == TC_VAL);

endmodule

// File: rtl/tinker_seq_ctrl.sv
// Multi-cycle sequencer: fetches over req/ack, hands off to the execution unit, writes back.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   IDLE       | waiting for start
//   FETCH      | fetch_req high until fetch_ack, instruction latched
//   DECODE     | one cycle: halt opcode / illegal check
//   EXECUTE    | ex_start on first cycle, wait for ex_done or watchdog
//   WRITEBACK  | one-cycle rf_we strobe, pc += 4, retire
//   HALT       | terminal, halt opcode retired
//   ERROR      | terminal, sticky error flag set
module tinker_seq_ctrl
    import tinker_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h2000,
    parameter int unsigned EXEC_TIMEOUT = 64,
    parameter logic [4:0]  HALT_OPCODE  = DEFAULT_HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        fetch_req,
    output logic [63:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic [31:0] instr_q,
    input  logic        illegal,
    input  logic        wr_allowed,
    output logic        ex_start,
    input  logic        ex_done,
    output logic        rf_we,
    output logic [63:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        err_illegal,
    output logic        err_timeout,
    output logic [31:0] retired_count
);

    state_t state;
    state_t state_nxt;

    logic load_instr;
    logic retire;
    logic adv_pc;
    logic set_ill;
    logic set_tmo;
    logic wr_q;
    logic wd_first;
    logic wd_tc;

    tinker_exec_watchdog #(
        .TIMEOUT (EXEC_TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_EXECUTE),
        .en    (state == ST_EXECUTE),
        .first (wd_first),
        .tc    (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_instr = 1'b0;
        retire     = 1'b0;
        adv_pc     = 1'b0;
        set_ill    = 1'b0;
        set_tmo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_ack) begin
                    load_instr = 1'b1;
                    state_nxt  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode_of(instr_q) == HALT_OPCODE) begin
                    retire    = 1'b1;
                    state_nxt = ST_HALT;
                end else if (illegal) begin
                    set_ill   = 1'b1;
                    state_nxt = ST_ERROR;
                end else begin
                    state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                // a result arriving on the last allowed cycle still wins over the watchdog
                if (ex_done) begin
                    state_nxt = ST_WRITEBACK;
                end else if (wd_tc) begin
                    set_tmo   = 1'b1;
                    state_nxt = ST_ERROR;
                end
            end
            ST_WRITEBACK: begin
                retire    = 1'b1;
                adv_pc    = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = state;
        endcase
    end

    // wr_allowed is captured on the way into WRITEBACK so rf_we is purely a registered decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            instr_q       <= '0;
            retired_count <= '0;
            err_illegal   <= 1'b0;
            err_timeout   <= 1'b0;
            wr_q          <= 1'b0;
        end else begin
            if (load_instr) instr_q <= fetch_data;
            if (adv_pc) pc <= pc + PC_INCR;
            if (retire) retired_count <= retired_count + 32'd1;
            if (set_ill) err_illegal <= 1'b1;
            if (set_tmo) err_timeout <= 1'b1;
            if (state == ST_EXECUTE && ex_done) wr_q <= wr_allowed;
        end
    end

    assign fetch_req  = (state == ST_FETCH);
    assign fetch_addr = pc;
    assign ex_start   = (state == ST_EXECUTE) && wd_first;
    assign rf_we      = (state == ST_WRITEBACK) && wr_q;
    assign busy       = (state == ST_FETCH) || (state == ST_DECODE) ||
                        (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_tinker_seq_ctrl.sv
// Randomized bench for tinker_seq_ctrl against a transaction-level pc/retire model.
module tb_tinker_seq_ctrl;

    localparam logic [63:0] RST_PC   = 64'h2000;
    localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] WRAP_OFF = WRAP_PC - RST_PC;
    localparam int          TMO      = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fetch_ack = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        illegal = 1'b0;
    logic        wr_allowed = 1'b0;
    logic        ex_done = 1'b0;

    logic        fetch_req, ex_start, rf_we, busy, halted, err_illegal, err_timeout;
    logic [63:0] fetch_addr, pc;
    logic [31:0] instr_q, retired_count;

    logic        w_fetch_req, w_ex_start, w_rf_we, w_busy, w_halted, w_err_illegal, w_err_timeout;
    logic [63:0] w_fetch_addr, w_pc;
    logic [31:0] w_instr_q, w_retired_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    tinker_seq_ctrl #(.RESET_PC(RST_PC), .EXEC_TIMEOUT(TMO), .HALT_OPCODE(5'h0F)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr_q(instr_q), .illegal(illegal), .wr_allowed(wr_allowed),
        .ex_start(ex_start), .ex_done(ex_done), .rf_we(rf_we), .pc(pc),
        .busy(busy), .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
        .retired_count(retired_count)
    );

    // Lockstep copy whose pc starts just below the 2^64 boundary
    tinker_seq_ctrl #(.RESET_PC(WRAP_PC), .EXEC_TIMEOUT(TMO), .HALT_OPCODE(5'h0F)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .instr_q(w_instr_q), .illegal(illegal), .wr_allowed(wr_allowed),
        .ex_start(w_ex_start), .ex_done(ex_done), .rf_we(w_rf_we), .pc(w_pc),
        .busy(w_busy), .halted(w_halted), .err_illegal(w_err_illegal), .err_timeout(w_err_timeout),
        .retired_count(w_retired_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; fetch_ack = 1'b0; ex_done = 1'b0; illegal = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_pc  = RST_PC;
        m_ret = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_fetch_addr"}, fetch_addr, RST_PC);
        chk({tag, "_instr_q"}, instr_q, 0);
        chk({tag, "_retired"}, retired_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fetch_req"}, fetch_req, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_ex_start"}, ex_start, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_errs"}, {err_illegal, err_timeout}, 0);
        chk({tag, "_w_pc"}, w_pc, WRAP_PC);
        chk({tag, "_w_addr"}, w_fetch_addr, WRAP_PC);
        chk({tag, "_w_misc"}, {w_fetch_req, w_ex_start, w_rf_we, w_busy, w_halted,
                               w_err_illegal, w_err_timeout}, 0);
        chk({tag, "_w_instr"}, w_instr_q, 0);
        chk({tag, "_w_retired"}, w_retired_count, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        chk("idle_busy", busy, 0);
        step();
        start = 1'b0;
        chk("start_fetch_req", fetch_req, 1);
    endtask

    // Drives one instruction from FETCH. rst_at >= 0 pulls reset on that EXECUTE cycle.
    task automatic run_instr(input int fdly, input int xdly, input bit wa,
                             input logic [31:0] word, input bit ill, input int rst_at);
        bit is_halt;
        bit is_tmo;
        int n_ex;
        is_halt = (word[31:27] == 5'h0F);
        is_tmo  = (xdly >= TMO);
        for (int i = 0; i <= fdly; i++) begin
            fetch_ack  = (i == fdly);
            fetch_data = (i == fdly) ? word : $urandom;
            ex_done    = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            chk("fetch_req", fetch_req, 1);
            chk("fetch_addr", fetch_addr, m_pc);
            chk("fetch_ex_start", ex_start, 0);
            chk("fetch_rf_we", rf_we, 0);
            step();
        end
        fetch_ack  = 1'b0;
        fetch_data = $urandom;
        illegal    = ill;
        wr_allowed = wa;
        ex_done    = 1'($urandom_range(0, 1));
        chk("dec_instr_q", instr_q, word);
        chk("dec_fetch_req", fetch_req, 0);
        chk("dec_busy", busy, 1);
        chk("dec_ex_start", ex_start, 0);
        step();
        illegal = 1'($urandom_range(0, 1));
        if (is_halt) begin
            m_ret++;
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_pc", pc, m_pc);
            chk("halt_retired", retired_count, m_ret);
            chk("halt_rf_we", rf_we, 0);
            return;
        end
        if (ill) begin
            chk("ill_err_illegal", err_illegal, 1);
            chk("ill_err_timeout", err_timeout, 0);
            chk("ill_busy", busy, 0);
            chk("ill_ex_start", ex_start, 0);
            chk("ill_retired", retired_count, m_ret);
            return;
        end
        n_ex = is_tmo ? TMO : xdly + 1;
        for (int i = 0; i < n_ex; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                ex_done = 1'b0;
                step();
                rst_n = 1'b1;
                m_pc  = RST_PC;
                m_ret = '0;
                chk("rst_pc", pc, RST_PC);
                chk("rst_busy", busy, 0);
                chk("rst_rf_we", rf_we, 0);
                chk("rst_fetch_req", fetch_req, 0);
                chk("rst_retired", retired_count, 0);
                chk("rst_instr_q", instr_q, 0);
                chk("rst_w_pc", w_pc, WRAP_PC);
                return;
            end
            ex_done = !is_tmo && (i == xdly);
            chk("ex_start", ex_start, (i == 0));
            chk("ex_busy", busy, 1);
            chk("ex_instr_q", instr_q, word);
            chk("ex_err_timeout", err_timeout, 0);
            chk("ex_rf_we", rf_we, 0);
            step();
        end
        ex_done = 1'($urandom_range(0, 1));
        if (is_tmo) begin
            chk("tmo_err_timeout", err_timeout, 1);
            chk("tmo_err_illegal", err_illegal, 0);
            chk("tmo_busy", busy, 0);
            chk("tmo_halted", halted, 0);
            return;
        end
        chk("wb_rf_we", rf_we, wa);
        chk("wb_instr_q", instr_q, word);
        chk("wb_ex_start", ex_start, 0);
        chk("wb_busy", busy, 1);
        step();
        wr_allowed = 1'($urandom_range(0, 1));
        m_pc  = m_pc + 64'd4;
        m_ret = m_ret + 32'd1;
        chk("ret_pc", pc, m_pc);
        chk("ret_retired", retired_count, m_ret);
        chk("ret_w_pc", w_pc, m_pc + WRAP_OFF);
        chk("ret_w_retired", w_retired_count, m_ret);
        chk("ret_fetch_req", fetch_req, 1);
    endtask

    // Terminal state must ignore start, acks and results for a few cycles
    task automatic check_terminal(input string tag, input bit exp_halt, input bit exp_ill,
                                  input bit exp_tmo);
        logic [63:0] hold_pc;
        hold_pc = pc;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; fetch_ack = 1'b1; ex_done = 1'b1;
            step();
            chk({tag, "_halted"}, halted, exp_halt);
            chk({tag, "_errs"}, {err_illegal, err_timeout}, {exp_ill, exp_tmo});
            chk({tag, "_busy"}, {busy, fetch_req, ex_start, rf_we}, 0);
            chk({tag, "_pc"}, pc, hold_pc);
        end
        start = 1'b0; fetch_ack = 1'b0; ex_done = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == 5'h0F) w[31:27] = 5'h01;
        return w;
    endfunction

    initial begin
        int fd;
        int xd;
        do_reset();
        check_reset_state("reset");
        do_start();

        run_instr(0, 0, 1'b1, 32'h0800_1234, 1'b0, -1);
        run_instr(3, 5, 1'b1, 32'h1234_5678, 1'b0, -1);
        run_instr(0, TMO - 1, 1'b0, 32'h2000_0001, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            fd = $urandom_range(0, 4);
            xd = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 5);
            run_instr(fd, xd, 1'($urandom_range(0, 1)), rand_word(), 1'b0, -1);
        end

        run_instr(1, 10, 1'b1, rand_word(), 1'b0, 4);
        chk("post_rst_idle_busy", busy, 0);
        do_start();
        run_instr(0, 0, 1'b1, rand_word(), 1'b0, -1);

        do_reset();
        check_reset_state("reset2");
        do_start();
        run_instr(2, 0, 1'b1, {5'h03, 27'h15A}, 1'b1, -1);
        check_terminal("ill_term", 1'b0, 1'b1, 1'b0);

        do_reset();
        do_start();
        run_instr(0, 1, 1'b1, rand_word(), 1'b0, -1);
        run_instr(1, 1000, 1'b1, rand_word(), 1'b0, -1);
        check_terminal("tmo_term", 1'b0, 1'b0, 1'b1);

        do_reset();
        do_start();
        run_instr(1, 0, 1'b1, {5'h0F, 27'h0}, 1'b0, -1);
        check_terminal("halt_term", 1'b1, 1'b0, 1'b0);
        chk("halt_term_retired", retired_count, 1);
        chk("halt_term_pc", pc, RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
